// File: rtl/comic_pkg.sv
// comic_pkg: constants and types shared by the comic reader blocks
// (page sequencer, page-ROM storage manager, VGA timing).
//   PAGE_W        width of every page index bus
//   NUM_PAGES_DEF default number of stored pages
//   fsm_state_e   page sequencer states
//   dir_e         page change direction
//   step_page()   wrap-around next/previous page computation
package comic_pkg;

    localparam int unsigned PAGE_W        = 10;
    localparam int unsigned NUM_PAGES_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLANK   = 2'd2
    } fsm_state_e;

    typedef enum logic {
        DIR_NEXT = 1'b0,
        DIR_PREV = 1'b1
    } dir_e;

    // Next/previous page with wrap-around; cur is assumed to be in 0..num_pages-1.
    function automatic logic [PAGE_W-1:0] step_page(input logic [PAGE_W-1:0] cur,
                                                     input dir_e             dir,
                                                     input int unsigned      num_pages);
        logic [PAGE_W-1:0] last;
        logic [PAGE_W-1:0] res;
        last = PAGE_W'(num_pages - 1);
        if (dir == DIR_NEXT) begin
            res = (cur == last) ? '0 : cur + 1'b1;
        end else begin
            res = (cur == '0) ? last : cur - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/page_turn_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, debounce counter and rising-edge pulse for
// one raw push button.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   btn_i    in  raw asynchronous button level, active-high
//   press_o  out one-cycle pulse when the accepted level goes 0->1
// The accepted level flips only after the synchronized input has differed from
// it for DEBOUNCE_CYC consecutive cycles; raw edge to press_o is DEBOUNCE_CYC+2.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q, sync2_q;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds how many cycles the synced input has already disagreed; the
    // flip happens on the cycle that would make it DEBOUNCE_CYC.
    always_comb begin
        cnt_d   = '0;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                lvl_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/page_turn_ctrl.sv
// page_turn_ctrl: page sequencer for the comic reader. Turns debounced buttons
// and an auto-play frame timer into the page index, committing changes only at
// frame boundaries and blanking the display around each change.
//   clk          in  system/pixel clock
//   rst_n        in  asynchronous active-low reset
//   btn_next     in  raw next-page button (async, active-high)
//   btn_prev     in  raw previous-page button (async, active-high)
//   auto_en      in  auto-play enable level
//   frame_start  in  one-cycle pulse at start of vertical blank
//   page         out current page index (0..NUM_PAGES-1)
//   blank        out display must output black while high
//   page_changed out one-cycle pulse in the cycle page takes its new value
module page_turn_ctrl
    import comic_pkg::*;
#(
    parameter int unsigned NUM_PAGES    = NUM_PAGES_DEF,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned AUTO_FRAMES  = 300,
    parameter int unsigned BLANK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              auto_en,
    input  logic              frame_start,
    output logic [PAGE_W-1:0] page,
    output logic              blank,
    output logic              page_changed
);

    localparam int unsigned AW = (AUTO_FRAMES  > 1) ? $clog2(AUTO_FRAMES)  : 1;
    localparam int unsigned BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    logic press_next, press_prev;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_next),
        .press_o (press_next)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_prev),
        .press_o (press_prev)
    );

    fsm_state_e        state_q, state_d;
    dir_e              dir_q, dir_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic              blank_q, blank_d;
    logic              chg_q, chg_d;
    logic [BW-1:0]     blank_cnt_q, blank_cnt_d;
    logic [AW-1:0]     auto_cnt_q, auto_cnt_d;

    logic man_req;
    dir_e man_dir;
    logic auto_exp;

    // Simultaneous next+prev presses cancel, so only a lone press is a request.
    assign man_req = press_next ^ press_prev;
    assign man_dir = press_next ? DIR_NEXT : DIR_PREV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_NEXT;
            page_q      <= '0;
            blank_q     <= 1'b0;
            chg_q       <= 1'b0;
            blank_cnt_q <= '0;
            auto_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            page_q      <= page_d;
            blank_q     <= blank_d;
            chg_q       <= chg_d;
            blank_cnt_q <= blank_cnt_d;
            auto_cnt_q  <= auto_cnt_d;
        end
    end

    // Auto-play timer: advances on frame_start only while idle, holds its
    // count while a change is in flight.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        auto_exp   = 1'b0;
        if (!auto_en || man_req) begin
            auto_cnt_d = '0;
        end else if (state_q == ST_IDLE && frame_start) begin
            if (auto_cnt_q == AW'(AUTO_FRAMES - 1)) begin
                auto_exp   = 1'b1;
                auto_cnt_d = '0;
            end else begin
                auto_cnt_d = auto_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        page_d      = page_q;
        blank_d     = blank_q;
        chg_d       = 1'b0;
        blank_cnt_d = blank_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A frame_start in this same cycle is not used for commit;
                // the change waits for the next frame boundary.
                if (man_req) begin
                    dir_d   = man_dir;
                    state_d = ST_PENDING;
                end else if (auto_exp) begin
                    dir_d   = DIR_NEXT;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    page_d = step_page(page_q, dir_q, NUM_PAGES);
                    chg_d  = 1'b1;
                    if (BLANK_FRAMES > 0) begin
                        blank_d     = 1'b1;
                        blank_cnt_d = '0;
                        state_d     = ST_BLANK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BLANK: begin
                if (frame_start) begin
                    if (blank_cnt_q == BW'(BLANK_FRAMES - 1)) begin
                        blank_d     = 1'b0;
                        blank_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                blank_d = 1'b0;
            end
        endcase
    end

    assign page         = page_q;
    assign blank        = blank_q;
    assign page_changed = chg_q;

endmodule

// File: tb/tb_page_turn_ctrl.sv
// Scoreboard bench for page_turn_ctrl: the stimulus process pushes the expected
// page of every change it causes; the monitor pops and checks on each
// page_changed pulse. Parameters: NUM_PAGES=5, DEBOUNCE_CYC=4, AUTO_FRAMES=3,
// BLANK_FRAMES=1.
module tb_page_turn_ctrl;
    import comic_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              btn_next, btn_prev, auto_en, frame_start;
    logic [PAGE_W-1:0] page;
    logic              blank, page_changed;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int mon_e;

    always #5 clk = ~clk;

    page_turn_ctrl #(
        .NUM_PAGES    (5),
        .DEBOUNCE_CYC (4),
        .AUTO_FRAMES  (3),
        .BLANK_FRAMES (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .auto_en      (auto_en),
        .frame_start  (frame_start),
        .page         (page),
        .blank        (blank),
        .page_changed (page_changed)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every commit must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && page_changed === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_change: got page %0d, expected no change (t=%0t)",
                         page, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_page", int'(page), mon_e);
                check("commit_blank", int'(blank), 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Hold button(s) 10 cycles (press lands after 6), then release and let the
    // release debounce settle.
    task automatic press_btn(input logic nx, input logic pv);
        btn_next = nx;
        btn_prev = pv;
        tick(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(12);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_change(input logic nx, input logic pv, input int exp_page);
        press_btn(nx, pv);
        exp_q.push_back(exp_page);
        pulse_fs();
        tick(2);
        check("chg_blank_hi", int'(blank), 1);
        pulse_fs();
        check("chg_blank_lo", int'(blank), 0);
        wait_drain("chg_drain");
        check("chg_page", int'(page), exp_page);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        auto_en     = 1'b0;
        frame_start = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("rst_page", int'(page), 0);
            check("rst_blank", int'(blank), 0);
            check("rst_chg", int'(page_changed), 0);
        end

        // First change with exact frame timing
        press_btn(1'b1, 1'b0);
        check("pend_page", int'(page), 0);
        check("pend_blank", int'(blank), 0);
        exp_q.push_back(1);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("first_page", int'(page), 1);
        check("first_blank", int'(blank), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("first_blank_hold", int'(blank), 1);
            check("first_chg_once", int'(page_changed), 0);
        end
        pulse_fs();
        check("first_blank_end", int'(blank), 0);
        wait_drain("first_drain");

        // Glitches shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1;
            tick(3);
            btn_next = 1'b0;
            tick(3);
        end
        tick(10);
        pulse_fs();
        tick(2);
        pulse_fs();
        tick(2);
        check("glitch_page", int'(page), 1);
        check("glitch_blank", int'(blank), 0);

        // Wrap-around both ways
        do_change(1'b0, 1'b1, 0);
        do_change(1'b0, 1'b1, 4);
        do_change(1'b1, 1'b0, 0);

        // Both buttons together cancel
        press_btn(1'b1, 1'b1);
        pulse_fs();
        tick(2);
        pulse_fs();
        tick(2);
        check("both_page", int'(page), 0);
        check("both_blank", int'(blank), 0);

        // Press during BLANK is dropped
        press_btn(1'b1, 1'b0);
        exp_q.push_back(1);
        pulse_fs();
        tick(2);
        check("drop_blank_hi", int'(blank), 1);
        press_btn(1'b1, 1'b0);
        check("drop_blank_hold", int'(blank), 1);
        pulse_fs();
        check("drop_blank_lo", int'(blank), 0);
        for (int i = 0; i < 3; i++) begin
            tick(2);
            pulse_fs();
        end
        tick(2);
        check("drop_page", int'(page), 1);
        wait_drain("drop_drain");

        // Auto-play: 3 counted frames, then commit frame, then blank frame
        rst_n = 1'b0;
        tick(2);
        rst_n   = 1'b1;
        auto_en = 1'b1;
        tick(2);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        for (int i = 1; i <= 14; i++) begin
            pulse_fs();
            tick(2);
            check("auto_page", int'(page), (i >= 14) ? 3 : (i >= 9) ? 2 : (i >= 4) ? 1 : 0);
        end
        wait_drain("auto_drain");
        // fs15 ends blank; fs16, fs17 counted; manual next restarts the count
        for (int i = 0; i < 3; i++) begin
            pulse_fs();
            tick(2);
        end
        exp_q.push_back(4);
        press_btn(1'b1, 1'b0);
        pulse_fs();
        tick(2);
        check("restart_manual_page", int'(page), 4);
        for (int i = 0; i < 3; i++) begin
            pulse_fs();
            tick(2);
        end
        check("restart_hold_page", int'(page), 4);
        exp_q.push_back(0);
        pulse_fs();
        tick(2);
        check("restart_req_page", int'(page), 4);
        pulse_fs();
        tick(2);
        check("restart_wrap_page", int'(page), 0);
        wait_drain("restart_drain");
        auto_en = 1'b0;
        pulse_fs();
        tick(2);

        // Asynchronous reset while a change is pending
        do_change(1'b1, 1'b0, 1);
        press_btn(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_page", int'(page), 0);
        check("arst_blank", int'(blank), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        pulse_fs();
        tick(2);
        check("arst_abort_page", int'(page), 0);
        check("arst_abort_blank", int'(blank), 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
